// File: rtl/mcb_write_arbiter_if.sv
// rtl/mcb_write_arbiter_if.sv - requester burst ports and MCB write-port bundle
interface mcb_write_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4,
  parameter int BL_W   = 6
);
  // requester side, index 0 = sprite renderer, 1 = command/pixel-data loader
  logic [1:0]              req;
  logic [1:0][BL_W-1:0]    bl;
  logic [1:0][ADDR_W-1:0]  addr;
  logic [1:0]              gnt;
  logic [1:0][DATA_W-1:0]  data;
  logic [1:0][MASK_W-1:0]  mask;
  logic [1:0]              valid;
  logic [1:0]              ready;
  logic [1:0]              done;
  logic [1:0]              err;

  // MCB command and write-data port
  logic                    cmd_en;
  logic [2:0]              cmd_instr;
  logic [BL_W-1:0]         cmd_bl;
  logic [ADDR_W-1:0]       cmd_byte_addr;
  logic                    cmd_full;
  logic                    wr_en;
  logic [DATA_W-1:0]       wr_data;
  logic [MASK_W-1:0]       wr_mask;
  logic                    wr_full;
  logic                    wr_underrun;
  logic                    wr_error;

  modport slave (
    input  req, bl, addr, data, mask, valid,
    input  cmd_full, wr_full, wr_underrun, wr_error,
    output gnt, ready, done, err,
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    output wr_en, wr_data, wr_mask
  );

  modport master (
    output req, bl, addr, data, mask, valid,
    output cmd_full, wr_full, wr_underrun, wr_error,
    input  gnt, ready, done, err,
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    input  wr_en, wr_data, wr_mask
  );
endinterface

// File: rtl/mcb_write_arbiter.sv
// rtl/mcb_write_arbiter.sv - two-requester burst arbiter in front of one MCB write port
module mcb_write_arbiter #(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 32,
  parameter int MASK_W         = 4,
  parameter int BL_W           = 6,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               calib_done_i,
  mcb_write_arbiter_if.slave bus,
  output logic               busy_o,
  output logic               sticky_err_o
);

  localparam logic [1:0] S_WAIT_CAL = 2'd0;
  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_CMD      = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic [BL_W-1:0]   bl_q, bl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BL_W:0]     cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              sticky_q, sticky_d;

  logic              winner;
  logic              any_req;
  logic              misaligned;
  logic              in_data;
  logic [1:0]        ready_w;
  logic              wr_fire;
  logic              last_word;
  logic              cmd_fire;

  // rr_q names the requester that wins a tie; a finished owner hands it to the other side
  always_comb begin
    any_req = |bus.req;
    if (bus.req == 2'b11) begin
      winner = FIXED_PRIORITY ? 1'b0 : rr_q;
    end else begin
      winner = bus.req[1];
    end
    misaligned = |bus.addr[winner][1:0];
  end

  assign in_data   = (state_q == S_DATA);
  assign ready_w   = gnt_q & {2{in_data & ~bus.wr_full}};
  assign wr_fire   = |(ready_w & bus.valid);
  assign last_word = (cnt_q == {1'b0, bl_q});
  assign cmd_fire  = (state_q == S_CMD) & ~bus.cmd_full;

  assign bus.gnt           = gnt_q;
  assign bus.ready         = ready_w;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.wr_en         = wr_fire;
  assign bus.wr_data       = in_data ? bus.data[owner_q] : '0;
  assign bus.wr_mask       = in_data ? bus.mask[owner_q] : '0;
  assign bus.cmd_en        = cmd_fire;
  assign bus.cmd_instr     = 3'b000;
  assign bus.cmd_bl        = bl_q;
  assign bus.cmd_byte_addr = addr_q;

  assign busy_o       = in_data | (state_q == S_CMD);
  assign sticky_err_o = sticky_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    bl_d     = bl_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    err_d    = 2'b00;
    sticky_d = sticky_q | bus.wr_underrun | bus.wr_error;

    case (state_q)
      S_WAIT_CAL: begin
        if (calib_done_i) begin
          state_d = S_IDLE;
        end
      end

      // Skip arbitration while a Done pulse is out so a requester that is
      // about to drop its level request is not granted a phantom burst.
      S_IDLE: begin
        if (!calib_done_i) begin
          state_d = S_WAIT_CAL;
        end else if (any_req && (done_q == 2'b00)) begin
          if (misaligned) begin
            done_d[winner] = 1'b1;
            err_d[winner]  = 1'b1;
            rr_d           = ~winner;
          end else begin
            owner_d = winner;
            bl_d    = bus.bl[winner];
            addr_d  = bus.addr[winner];
            cnt_d   = '0;
            gnt_d   = winner ? 2'b10 : 2'b01;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (wr_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (last_word) begin
            state_d = S_CMD;
          end
        end
      end

      // calib_done is only honoured once the command is out, never mid-burst
      S_CMD: begin
        if (cmd_fire) begin
          gnt_d           = 2'b00;
          done_d[owner_q] = 1'b1;
          rr_d            = ~owner_q;
          state_d         = calib_done_i ? S_IDLE : S_WAIT_CAL;
        end
      end

      default: begin
        state_d = S_WAIT_CAL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_WAIT_CAL;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      bl_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      bl_q     <= bl_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_mcb_write_arbiter.sv
// tb/tb_mcb_write_arbiter.sv - scoreboard bench for mcb_write_arbiter
module tb_mcb_write_arbiter;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int BL_W   = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic calib, fcalib;
  logic busy, sticky, fbusy, fsticky;

  always #5 clk = ~clk;

  mcb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .BL_W(BL_W)) bus ();
  mcb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .BL_W(BL_W)) fbus ();

  mcb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .BL_W(BL_W),
                      .FIXED_PRIORITY(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .calib_done_i(calib), .bus(bus),
    .busy_o(busy), .sticky_err_o(sticky));

  mcb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .BL_W(BL_W),
                      .FIXED_PRIORITY(1'b1)) dutf (
    .clk_i(clk), .rst_ni(rst_n), .calib_done_i(fcalib), .bus(fbus),
    .busy_o(fbusy), .sticky_err_o(fsticky));

  int compared = 0;
  int mismatched = 0;

  logic [63:0] wr_q[$];
  logic [63:0] cmd_q[$];
  int          gnt_log[$];
  int          fgnt_log[$];
  int          wr_cnt = 0;
  int          cmd_cnt = 0;
  logic [1:0]  gnt_prev = 2'b00;
  logic [1:0]  fgnt_prev = 2'b00;
  logic [63:0] mon_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // MCB-side scoreboard and grant logging
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) begin
        chk("wr_en_while_wr_full", bus.wr_full, 0);
        chk("wr_expected_nonempty", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          mon_e = wr_q.pop_front();
          chk("wr_word", {28'b0, bus.wr_mask, bus.wr_data}, mon_e);
        end
        wr_cnt <= wr_cnt + 1;
      end
      if (bus.cmd_en) begin
        chk("cmd_en_while_cmd_full", bus.cmd_full, 0);
        chk("cmd_expected_nonempty", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) begin
          mon_e = cmd_q.pop_front();
          chk("cmd_fields", {25'b0, bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr}, mon_e);
        end
        cmd_cnt <= cmd_cnt + 1;
      end
      if (bus.gnt[0] && !gnt_prev[0]) gnt_log.push_back(0);
      if (bus.gnt[1] && !gnt_prev[1]) gnt_log.push_back(1);
      if (fbus.gnt[0] && !fgnt_prev[0]) fgnt_log.push_back(0);
      if (fbus.gnt[1] && !fgnt_prev[1]) fgnt_log.push_back(1);
    end
    gnt_prev  <= bus.gnt;
    fgnt_prev <= fbus.gnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One burst from requester r; words are base+i with mask i^5.
  task automatic burst(input int r, input int bl, input logic [29:0] addr, input logic [31:0] base,
                       input int stall_after, input int stall_len, input int cfull_len);
    int n, guard, wr0, cmd0;
    logic acc;
    wr0 = wr_cnt;
    cmd0 = cmd_cnt;
    bus.req[r]  = 1'b1;
    bus.bl[r]   = bl[5:0];
    bus.addr[r] = addr;
    if (cfull_len > 0) bus.cmd_full = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.gnt[r] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("gnt_seen", bus.gnt[r], 1);
    chk("busy_in_burst", busy, 1);
    cmd_q.push_back({25'b0, 3'b000, bl[5:0], addr});
    for (int i = 0; i <= bl; i++) wr_q.push_back({28'b0, i[3:0] ^ 4'h5, base + i});
    step();
    n = 0;
    guard = 0;
    while (n <= bl && guard < 300) begin
      bus.valid[r] = 1'b1;
      bus.data[r]  = base + n;
      bus.mask[r]  = n[3:0] ^ 4'h5;
      @(negedge clk);
      acc = bus.ready[r];
      step();
      guard++;
      if (acc) begin
        n++;
        if (n == stall_after && stall_len > 0) begin
          bus.wr_full = 1'b1;
          for (int k = 0; k < stall_len; k++) begin
            @(negedge clk);
            chk("ready_low_while_full", bus.ready[r], 0);
            chk("wr_en_low_while_full", bus.wr_en, 0);
            step();
          end
          bus.wr_full = 1'b0;
        end
      end
    end
    bus.valid[r] = 1'b0;
    chk("words_written", wr_cnt - wr0, bl + 1);
    if (cfull_len > 0) begin
      for (int k = 0; k < cfull_len; k++) begin
        @(negedge clk);
        chk("cmd_en_deferred", bus.cmd_en, 0);
        chk("done_deferred", bus.done[r], 0);
        step();
      end
      bus.cmd_full = 1'b0;
    end
    guard = 0;
    @(negedge clk);
    while (!bus.done[r] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("done_pulse", bus.done[r], 1);
    chk("err_quiet", bus.err[r], 0);
    chk("gnt_dropped", bus.gnt[r], 0);
    chk("single_cmd", cmd_cnt - cmd0, 1);
    step();
    bus.req[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, seen, wr0, cmd0, log0;
    rst_n = 1'b0;
    calib = 1'b0;
    fcalib = 1'b0;
    bus.req = '0; bus.bl = '0; bus.addr = '0; bus.data = '0; bus.mask = '0; bus.valid = '0;
    bus.cmd_full = 1'b0; bus.wr_full = 1'b0; bus.wr_underrun = 1'b0; bus.wr_error = 1'b0;
    fbus.req = '0; fbus.bl = '0; fbus.addr = '0; fbus.data = '0; fbus.mask = '0; fbus.valid = '0;
    fbus.cmd_full = 1'b0; fbus.wr_full = 1'b0; fbus.wr_underrun = 1'b0; fbus.wr_error = 1'b0;
    bus.data[0] = 32'hFFFF_FFFF;
    bus.mask[0] = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_handshake", {bus.gnt, bus.ready, bus.done, bus.err}, 0);
    chk("rst_mcb", {bus.cmd_en, bus.wr_en, bus.cmd_instr, bus.cmd_bl, bus.cmd_byte_addr}, 0);
    chk("rst_status", {busy, sticky, bus.wr_mask, bus.wr_data}, 0);
    step();
    rst_n = 1'b1;
    bus.data[0] = '0;
    bus.mask[0] = '0;

    // T1: no grant before calibration, grant two cycles after calib_done rises
    bus.req[0] = 1'b1;
    bus.bl[0] = '0;
    bus.addr[0] = 30'h100;
    repeat (4) @(negedge clk);
    chk("t1_no_gnt_precal", bus.gnt[0], 0);
    step();
    calib = 1'b1;
    @(negedge clk);
    chk("t1_gnt_cal_plus0", bus.gnt[0], 0);
    @(negedge clk);
    chk("t1_gnt_cal_plus1", bus.gnt[0], 0);
    @(negedge clk);
    chk("t1_gnt_cal_plus2", bus.gnt[0], 1);
    burst(0, 0, 30'h100, 32'h55, 0, 0, 0);

    // requester 1 burst leaves the round-robin pointer favouring requester 0
    burst(1, 1, 30'h400, 32'h1000, 0, 0, 0);

    // T3: both requesters held, single-word bursts alternate 0,1,0,1
    gnt_log.delete();
    bus.bl = '0;
    bus.addr[0] = 30'h200; bus.addr[1] = 30'h300;
    bus.data[0] = 32'hAAAA_0000; bus.data[1] = 32'hBBBB_0000;
    bus.mask = '0;
    for (int k = 0; k < 2; k++) begin
      wr_q.push_back({32'b0, 32'hAAAA_0000}); cmd_q.push_back({34'b0, 30'h200});
      wr_q.push_back({32'b0, 32'hBBBB_0000}); cmd_q.push_back({34'b0, 30'h300});
    end
    bus.req = 2'b11;
    bus.valid = 2'b11;
    seen = 0;
    guard = 0;
    while (seen < 4 && guard < 100) begin
      @(negedge clk);
      if (|bus.done) seen++;
      guard++;
    end
    chk("t3_four_dones", seen, 4);
    step();
    bus.req = 2'b00;
    bus.valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("t3_grant_count", gnt_log.size(), 4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++) chk("t3_rr_order", gnt_log[k], k % 2);

    // T2, T4, T5
    burst(0, 3, 30'h100, 32'hA, 0, 0, 0);
    burst(0, 7, 30'h600, 32'h100, 3, 5, 0);
    burst(0, 1, 30'h700, 32'h200, 0, 0, 10);

    // T6: misaligned address is rejected with Done+Err and moves no data
    wr0 = wr_cnt; cmd0 = cmd_cnt; log0 = gnt_log.size();
    step();
    bus.bl[1] = '0;
    bus.addr[1] = 30'h102;
    bus.req[1] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.done[1] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("t6_done1", bus.done[1], 1);
    chk("t6_err1", bus.err[1], 1);
    chk("t6_no_gnt1", bus.gnt[1], 0);
    step();
    bus.req[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_no_wr", wr_cnt - wr0, 0);
    chk("t6_no_cmd", cmd_cnt - cmd0, 0);
    chk("t6_no_grant_logged", gnt_log.size() - log0, 0);
    chk("t6_sticky_before", sticky, 0);
    step();
    bus.wr_error = 1'b1;
    step();
    bus.wr_error = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_sticky_set", sticky, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_sticky_cleared_by_reset", sticky, 0);
    chk("t6_busy_reset", busy, 0);

    // fixed priority: requester 0 wins every tie while its request stays up
    fcalib = 1'b1;
    fbus.addr[0] = 30'h0; fbus.addr[1] = 30'h4;
    fbus.data[0] = 32'h1111_1111; fbus.data[1] = 32'h2222_2222;
    fbus.req = 2'b11;
    fbus.valid = 2'b11;
    fgnt_log.delete();
    step();
    rst_n = 1'b1;
    seen = 0;
    guard = 0;
    while (seen < 3 && guard < 100) begin
      @(negedge clk);
      if (|fbus.done) seen++;
      guard++;
    end
    step();
    fbus.req[0] = 1'b0;
    fbus.valid[0] = 1'b0;
    guard = 0;
    while (seen < 4 && guard < 100) begin
      @(negedge clk);
      if (|fbus.done) seen++;
      guard++;
    end
    chk("fixed_four_dones", seen, 4);
    step();
    fbus.req = 2'b00;
    fbus.valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("fixed_grant_count", fgnt_log.size(), 4);
    for (int k = 0; k < 4 && k < fgnt_log.size(); k++) chk("fixed_order", fgnt_log[k], (k == 3) ? 1 : 0);
    chk("scoreboard_wr_drained", wr_q.size(), 0);
    chk("scoreboard_cmd_drained", cmd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
